// File: rtl/fifo_rd_sched_pkg.sv
// Shared types and helpers for the FIFO read-side burst scheduler.
package fifo_rd_sched_pkg;

  localparam int MAX_NREQ = 8;
  localparam int MAX_ID_W = $clog2(MAX_NREQ);

  typedef enum logic {ST_IDLE, ST_BURST} state_e;

  // Zero-length requests still move one word; oversize requests are capped.
  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_burst);
    if (len == 0) return 1;
    if (len > max_burst) return max_burst;
    return len;
  endfunction

  function automatic logic [MAX_NREQ-1:0] onehot(input int unsigned idx);
    logic [MAX_NREQ-1:0] r;
    r = '0;
    r[idx[MAX_ID_W-1:0]] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/fifo_rd_sched_if.sv
// Bundle of the FIFO read port, requester and consumer signals around the scheduler.
interface fifo_rd_sched_if #(
  parameter int NREQ       = 4,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_W    = 4,
  parameter int ID_W       = $clog2(NREQ)
);
  logic [NREQ-1:0]         req;
  logic [NREQ*BURST_W-1:0] req_len;
  logic                    rempty;
  logic [DATA_WIDTH-1:0]   rdata;
  logic                    rinc;
  logic [NREQ-1:0]         gnt;
  logic                    out_valid;
  logic                    out_ready;
  logic [DATA_WIDTH-1:0]   out_data;
  logic [ID_W-1:0]         out_id;
  logic                    out_last;
  logic                    busy;

  modport master (
    input  req, req_len, rempty, rdata, out_ready,
    output rinc, gnt, out_valid, out_data, out_id, out_last, busy
  );

  modport slave (
    output req, req_len, rempty, rdata, out_ready,
    input  rinc, gnt, out_valid, out_data, out_id, out_last, busy
  );
endinterface

// File: rtl/fifo_rd_sched_rr_arbiter.sv
// Combinational round-robin pick: the search starts one past the last served requester.
module rr_arbiter
  import fifo_rd_sched_pkg::*;
#(
  parameter int NREQ = 4,
  localparam int ID_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] last_id,
  output logic            any,
  output logic [ID_W-1:0] win_id
);

  int              idx;
  logic [ID_W-1:0] cand;

  // Scan farthest-first so the nearest active requester after last_id is written last.
  always_comb begin
    any    = 1'b0;
    win_id = '0;
    idx    = 0;
    cand   = '0;
    for (int i = NREQ; i >= 1; i--) begin
      idx  = (int'(last_id) + i) % NREQ;
      cand = ID_W'(idx);
      if (req[cand]) begin
        any    = 1'b1;
        win_id = cand;
      end
    end
  end

endmodule

// File: rtl/fifo_rd_sched.sv
// Read-side scheduler: shares one FIFO read port among NREQ consumers with round-robin burst grants.
module fifo_rd_sched
  import fifo_rd_sched_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 8,
  localparam int BURST_W   = $clog2(MAX_BURST + 1),
  localparam int ID_W      = $clog2(NREQ)
) (
  input  logic            rclk,
  input  logic            rrst_n,
  fifo_rd_sched_if.master bus
);

  state_e               state_q, state_d;
  logic [ID_W-1:0]      cur_id_q, cur_id_d;
  logic [ID_W-1:0]      last_id_q, last_id_d;
  logic [BURST_W-1:0]   beats_left_q, beats_left_d;

  logic [BURST_W-1:0]   len_arr [NREQ];
  logic                 arb_any;
  logic [ID_W-1:0]      arb_win;
  logic                 in_burst;
  logic                 out_valid;
  logic                 out_last;
  logic                 rinc;
  logic [MAX_NREQ-1:0]  gnt_full;
  logic [DATA_WIDTH-1:0] rdata;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_len
      assign len_arr[gi] = bus.req_len[gi*BURST_W +: BURST_W];
    end
  endgenerate

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req     (bus.req),
    .last_id (last_id_q),
    .any     (arb_any),
    .win_id  (arb_win)
  );

  // Outputs depend only on registered state plus rempty/out_ready.
  assign in_burst  = (state_q == ST_BURST);
  assign out_valid = in_burst && !bus.rempty;
  assign out_last  = in_burst && (beats_left_q == BURST_W'(1));
  assign rinc      = out_valid && bus.out_ready;
  assign gnt_full  = onehot(32'(cur_id_q));
  assign rdata     = bus.rdata;

  assign bus.rinc      = rinc;
  assign bus.out_valid = out_valid;
  assign bus.out_last  = out_last;
  assign bus.out_data  = rdata;
  assign bus.out_id    = cur_id_q;
  assign bus.busy      = in_burst;
  assign bus.gnt       = in_burst ? gnt_full[NREQ-1:0] : '0;

  always_comb begin
    state_d      = state_q;
    cur_id_d     = cur_id_q;
    last_id_d    = last_id_q;
    beats_left_d = beats_left_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          cur_id_d     = arb_win;
          beats_left_d = BURST_W'(clamp_len(32'(len_arr[arb_win]), MAX_BURST));
          state_d      = ST_BURST;
        end
      end
      ST_BURST: begin
        if (rinc) begin
          beats_left_d = beats_left_q - BURST_W'(1);
          if (out_last) begin
            last_id_d = cur_id_q;
            state_d   = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state_q      <= ST_IDLE;
      cur_id_q     <= '0;
      last_id_q    <= ID_W'(NREQ - 1);
      beats_left_q <= '0;
    end else begin
      state_q      <= state_d;
      cur_id_q     <= cur_id_d;
      last_id_q    <= last_id_d;
      beats_left_q <= beats_left_d;
    end
  end

endmodule

// File: doc/fifo_rd_sched.md
# fifo_rd_sched

Read-side scheduler for the asynchronous FIFO. It shares the single FIFO read port among `NREQ` consumers using round-robin burst grants. It drives the FIFO's `rinc` from a valid/ready output channel and never reads while `rempty` is high. It sits in the `rclk` domain between the FIFO read pointer/empty logic plus memory read port, and the downstream consumers.

## Interface
- `NREQ`, 4: number of requesters (2..8).
- `DATA_WIDTH`, 8: FIFO word width.
- `MAX_BURST`, 8: maximum beats per grant.
- `BURST_W`, `$clog2(MAX_BURST+1)`: width of length fields.

- `rclk`  in  1  read-domain clock.
- `rrst_n`  in  1  asynchronous, active-low reset.
- `req`  in  `NREQ`  per-requester level request.
- `req_len`  in  `NREQ*BURST_W`  burst length per requester, slice i at `[i*BURST_W +: BURST_W]`.
- `rempty`  in  1  FIFO empty flag (registered in FIFO).
- `rdata`  in  `DATA_WIDTH`  FIFO head word (combinational memory read at current `raddr`).
- `rinc`  out  1  FIFO read increment.
- `gnt`  out  `NREQ`  one-hot grant, held for the whole burst.
- `out_valid`  out  1  beat available.
- `out_ready`  in  1  consumer accepts beat.
- `out_data`  out  `DATA_WIDTH`  beat data.
- `out_id`  out  `$clog2(NREQ)`  index of granted requester.
- `out_last`  out  1  final beat of burst.
- `busy`  out  1  burst in progress.

## Operation
- FSM states:
  - IDLE: no grant. If any `req` bit is high, the round-robin winner is chosen, starting the search at `last_id+1` modulo `NREQ`. The winner's index is latched into `cur_id`. Its length is latched into `beats_left`; `req_len` of 0 or greater than `MAX_BURST` is clamped to 1 or `MAX_BURST`. Transition to BURST. With no request, the FSM stays in IDLE.
  - BURST: `gnt` = onehot(`cur_id`), `busy`=1.
    - Beat signals: `out_valid` = `!rempty`, `out_data` = `rdata`, `out_id` = `cur_id`, `out_last` = (`beats_left`==1).
    - `rinc` = `out_valid & out_ready`.
    - Each handshake decrements `beats_left`.
    - The handshake with `out_last`=1 updates `last_id` to `cur_id` and transitions to IDLE.
- A grant is committed: dropping `req` mid-burst does not end the burst.
- A requester that keeps `req` high is regranted only after every other active requester has been served.
- Empty mid-burst: `out_valid` drops, `rinc`=0, `beats_left` holds, and the FSM stays in BURST until data arrives. There is no timeout.
- Backpressure: while `out_ready`=0, `rinc`=0 and `out_data` stays the FIFO head, so the beat is stable.
- `rinc` is never high when `rempty`=1. The FIFO's own `rinc & ~rempty` guard is redundant but harmless.

## Timing
- Reset values: FSM=IDLE, `gnt`=0, `busy`=0, `rinc`=0, `out_valid`=0, `out_last`=0, `out_id`=0, `cur_id`=0, `beats_left`=0, `last_id`=`NREQ-1` (requester 0 wins first).
- Request to grant: `req` sampled in IDLE at edge k; `gnt`/`busy` are high after edge k; the first beat can handshake in cycle k+1.
- Throughput: 1 beat per cycle while `!rempty & out_ready`.
- Between bursts: exactly one IDLE cycle after each last beat.
- `rinc`, `out_valid` and `out_last` are combinational from registered state, `rempty` and `out_ready`. There is no combinational path from `req`/`req_len` to any output.
- An `rempty` rise after a read is honoured the same cycle, because it comes from the FIFO's registered flag.
- Asserting `rrst_n` low mid-burst aborts immediately: all outputs go to their reset values. Untransferred words remain in the FIFO.

## Structure
- Package `fifo_rd_sched_pkg`:
  - state enum `{ST_IDLE, ST_BURST}`.
  - function `clamp_len`.
  - function `onehot(idx)`.
- Sub-module `rr_arbiter`: parameter `NREQ`; inputs `req`, `last_id`; outputs `any`, `win_id`. It is purely combinational rotate / priority-pick. The top holds the FSM, counters and registers.

## Test plan
- FIFO holds 6 words (A..F); `req[0]`=1, `len0`=4, `out_ready`=1 → grant on cycle 1; beats A,B,C,D with `out_id`=0 and `out_last` on D; 4 `rinc` pulses; FIFO left with E,F; `busy` low after D.
- `req[0]` and `req[2]` both high, lens 2/3, FIFO 10 words → burst id0 (2 beats), one IDLE cycle, burst id2 (3 beats); then id0 again if still requesting.
- FIFO empties after 2 of 5 beats → `out_valid`=0 and `rinc`=0 while empty, `beats_left`=3 held; refill → remaining 3 beats, `out_last` on the 5th.
- `out_ready` toggled 1,0,0,1 → `out_data` stable through the stall, no `rinc` while ready is low, no duplicate or lost word.
- `req_len`=0 and `req_len`=15 with `MAX_BURST`=8 → exactly 1 beat and exactly 8 beats respectively.
- `rrst_n` asserted after 2 of 4 beats → `gnt`, `busy`, `rinc`, `out_valid` go to 0 immediately; after release, `last_id`=`NREQ-1` so requester 0 is granted first.
